// File: rtl/uart_receiver_crc8_pkg.sv
// rtl/uart_receiver_crc8_pkg.sv - shared UART receive types and defaults
package uart_receiver_crc8_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_t;

   localparam int         DEFAULT_CLKS_PER_BIT = 5208;
   localparam logic [7:0] DEFAULT_CRC_POLY     = 8'h07;

endpackage

// File: rtl/uart_receiver_crc8_if.sv
// rtl/uart_receiver_crc8_if.sv - received byte stream and accumulator status
interface uart_receiver_crc8_if;

   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_error;
   logic       busy;
   logic [7:0] crc8;
   logic [7:0] byte_count;

   modport master (
      output data_out, data_valid, frame_error, busy, crc8, byte_count
   );

   modport slave (
      input data_out, data_valid, frame_error, busy, crc8, byte_count
   );

endinterface

// File: rtl/uart_receiver_crc8_crc8_step.sv
// rtl/uart_receiver_crc8_crc8_step.sv - one-byte MSB-first CRC-8 update, shared with the transmitter
module crc8_step
   import uart_receiver_crc8_pkg::*;
#(
   parameter logic [7:0] POLY = DEFAULT_CRC_POLY
) (
   input  logic [7:0] crc_in,
   input  logic [7:0] byte_in,
   output logic [7:0] crc_out
);

   logic [7:0] c;
   logic       fb;

   always_comb begin
      c  = crc_in;
      fb = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         fb = c[7] ^ byte_in[i];
         c  = {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
      end
      crc_out = c;
   end

endmodule

// File: rtl/uart_receiver_crc8.sv
// rtl/uart_receiver_crc8.sv - 8N1 UART receiver with running CRC-8 and good-byte count
module uart_receiver_crc8
   import uart_receiver_crc8_pkg::*;
#(
   parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter logic [7:0] CRC_POLY     = DEFAULT_CRC_POLY
) (
   input  logic                  clock,
   input  logic                  nreset,
   input  logic                  data_in,
   input  logic                  clear,
   uart_receiver_crc8_if.master  rx
);

   localparam int             CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

   logic [1:0]       sync_q;
   logic             rx_s;
   rx_state_t        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [7:0]       shift, shift_nxt;
   logic             good_byte, bad_byte;

   logic [7:0]       data_out_q, crc_q, count_q, crc_next;
   logic             data_valid_q, frame_error_q;

   assign rx_s = sync_q[1];

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         sync_q <= 2'b11;
         state  <= ST_IDLE;
         cnt    <= '0;
         idx    <= 3'd0;
         shift  <= 8'h00;
      end else begin
         sync_q <= {sync_q[0], data_in};
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         idx    <= idx_nxt;
         shift  <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_W'(1);
      idx_nxt   = idx;
      shift_nxt = shift;
      good_byte = 1'b0;
      bad_byte  = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_nxt = '0;
            if (!rx_s) state_nxt = ST_START;
         end
         ST_START: begin
            // Re-check the line at mid start bit so short glitches are dropped
            if (cnt == HALF_LAST) begin
               cnt_nxt   = '0;
               idx_nxt   = 3'd0;
               state_nxt = rx_s ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt        = '0;
               shift_nxt[idx] = rx_s;
               if (idx == 3'd7) state_nxt = ST_STOP;
               else             idx_nxt   = idx + 3'd1;
            end
         end
         ST_STOP: begin
            // Leaving at mid stop bit leaves half a bit to catch a back-to-back start
            if (cnt == BIT_LAST) begin
               cnt_nxt   = '0;
               state_nxt = ST_IDLE;
               good_byte = rx_s;
               bad_byte  = !rx_s;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   crc8_step #(.POLY(CRC_POLY)) u_crc (
      .crc_in  (crc_q),
      .byte_in (shift),
      .crc_out (crc_next)
   );

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         data_out_q    <= 8'h00;
         data_valid_q  <= 1'b0;
         frame_error_q <= 1'b0;
         crc_q         <= 8'h00;
         count_q       <= 8'h00;
      end else begin
         data_valid_q  <= good_byte;
         frame_error_q <= bad_byte;
         if (good_byte) data_out_q <= shift;
         // clear wins over a coincident byte: that byte is shown but not accumulated
         if (clear) begin
            crc_q   <= 8'h00;
            count_q <= 8'h00;
         end else if (good_byte) begin
            crc_q   <= crc_next;
            count_q <= count_q + 8'd1;
         end
      end
   end

   assign rx.data_out    = data_out_q;
   assign rx.data_valid  = data_valid_q;
   assign rx.frame_error = frame_error_q;
   assign rx.busy        = (state != ST_IDLE);
   assign rx.crc8        = crc_q;
   assign rx.byte_count  = count_q;

endmodule

// File: tb/tb_uart_receiver_crc8.sv
// tb/tb_uart_receiver_crc8.sv - bench for uart_receiver_crc8 with a byte-level model
`timescale 1ns/1ps
module tb_uart_receiver_crc8;

   localparam int  CPB    = 16;
   localparam real BIT_NS = 160.0;

   logic clock   = 1'b0;
   logic nreset  = 1'b0;
   logic data_in = 1'b1;
   logic clear   = 1'b0;

   uart_receiver_crc8_if rx ();

   uart_receiver_crc8 #(.CLKS_PER_BIT(CPB), .CRC_POLY(8'h07)) dut (
      .clock   (clock),
      .nreset  (nreset),
      .data_in (data_in),
      .clear   (clear),
      .rx      (rx)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit         good;
      logic [7:0] data;
   } ev_t;

   ev_t        exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic       clr_at_edge = 1'b0;
   logic [7:0] m_crc, m_data, m_count;
   int         fe_count = 0;
   int         last_pulse_cyc = 0;
   bit         clr_coinc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, want, cyc);
      end
   endtask

   // Standard table-free CRC-8 byte update: xor the byte in, then eight polynomial reductions
   function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] b);
      logic [7:0] r;
      r = c ^ b;
      repeat (8) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      return r;
   endfunction

   initial forever begin
      @(posedge clock);
      cyc++;
      clr_at_edge = clear;
   end

   initial begin
      ev_t  e;
      logic dv, fe;
      bit   prev_pulse;
      prev_pulse = 0;
      forever begin
         @(negedge clock);
         if (!nreset) begin
            m_crc = 8'h00; m_data = 8'h00; m_count = 8'h00;
            prev_pulse = 0;
            exp_q.delete();
         end else begin
            dv = rx.data_valid;
            fe = rx.frame_error;
            check("pulse_rules", 32'((dv && fe) || ((dv || fe) && prev_pulse)), 0);
            if (dv || fe) begin
               last_pulse_cyc = cyc;
               if (fe) fe_count++;
               if (dv && clr_at_edge) clr_coinc = 1;
               if (exp_q.size() == 0) begin
                  check("unexpected_pulse", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("pulse_kind", 32'(dv), 32'(e.good));
                  if (e.good && dv) begin
                     m_data = e.data;
                     if (!clr_at_edge) begin
                        m_crc   = crc_ref(m_crc, e.data);
                        m_count = m_count + 8'd1;
                     end
                  end
               end
            end
            if (clr_at_edge) begin
               m_crc = 8'h00; m_count = 8'h00;
            end
            check("state", {8'h00, rx.data_out, rx.crc8, rx.byte_count},
                           {8'h00, m_data, m_crc, m_count});
            prev_pulse = dv || fe;
         end
      end
   end

   task automatic send_frame(input logic [7:0] b, input bit stop, input real bit_ns);
      exp_q.push_back('{good: stop, data: b});
      data_in = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         data_in = b[i];
         #(bit_ns);
      end
      data_in = stop;
      #(bit_ns);
      data_in = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      check("drain", exp_q.size(), 0);
      repeat (4) @(negedge clock);
   endtask

   task automatic do_clear();
      @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      int  start_cyc;
      int  fe_before;
      bit  saw_busy;
      int  n;
      logic [7:0] msg [9];
      msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

      // T1: reset values, mid-frame reset, then first frame and its latency
      repeat (3) @(negedge clock);
      check("rst_outputs", {rx.data_out, rx.crc8, rx.byte_count, 5'b0, rx.data_valid, rx.frame_error, rx.busy}, 0);
      nreset = 1'b1;
      repeat (5) @(negedge clock);
      data_in = 1'b0;
      repeat (3 * CPB) @(negedge clock);
      check("busy_mid_frame", 32'(rx.busy), 1);
      nreset  = 1'b0;
      data_in = 1'b1;
      repeat (2) @(negedge clock);
      check("rst_mid_frame", {rx.data_out, rx.crc8, rx.byte_count, 5'b0, rx.data_valid, rx.frame_error, rx.busy}, 0);
      nreset = 1'b1;
      repeat (40) @(negedge clock);
      check("idle_after_rst", 32'(rx.busy), 0);
      start_cyc = cyc;
      send_frame(8'hA5, 1, BIT_NS);
      wait_drain(200);
      check("latency", 32'((last_pulse_cyc - start_cyc) >= 154 && (last_pulse_cyc - start_cyc) <= 156), 1);
      check("t1_crc", rx.crc8, 8'h72);
      check("t1_count", rx.byte_count, 1);
      check("t1_data", rx.data_out, 8'hA5);

      // T2: CRC-8 check string, back-to-back frames
      do_clear();
      for (int i = 0; i < 9; i++) send_frame(msg[i], 1, BIT_NS);
      wait_drain(200);
      check("t2_crc", rx.crc8, 8'hF4);
      check("t2_count", rx.byte_count, 9);
      check("t2_model_crc", m_crc, 8'hF4);

      // T3: bad stop bit, then a good byte
      fe_before = fe_count;
      send_frame(8'h3C, 0, BIT_NS);
      #(2 * BIT_NS);
      wait_drain(200);
      check("t3_fe_count", fe_count - fe_before, 1);
      check("t3_crc_hold", rx.crc8, 8'hF4);
      check("t3_count_hold", rx.byte_count, 9);
      send_frame(8'h01, 1, BIT_NS);
      wait_drain(200);
      check("t3_crc", rx.crc8, 8'hC5);
      check("t3_count", rx.byte_count, 10);

      // T4: short glitch on an idle line
      do_clear();
      @(negedge clock);
      data_in = 1'b0;
      repeat (3) @(negedge clock);
      data_in = 1'b1;
      saw_busy = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (rx.busy) saw_busy = 1;
      end
      check("t4_busy_seen", 32'(saw_busy), 1);
      n = 0;
      while (rx.busy && n < 40) begin
         @(negedge clock);
         n++;
      end
      check("t4_busy_clear", 32'(rx.busy), 0);
      repeat (20) @(negedge clock);
      send_frame(8'h00, 1, BIT_NS);
      wait_drain(200);
      check("t4_crc", rx.crc8, 8'h00);
      check("t4_count", rx.byte_count, 1);

      // T5: clear coincident with a good byte
      do_clear();
      send_frame(8'h01, 1, BIT_NS);
      wait_drain(200);
      check("t5_crc_01", rx.crc8, 8'h07);
      send_frame(8'h02, 1, BIT_NS);
      wait_drain(200);
      @(negedge clock);
      fork
         send_frame(8'h03, 1, BIT_NS);
         begin
            repeat (154) @(posedge clock);
            @(negedge clock);
            clear = 1'b1;
            @(negedge clock);
            clear = 1'b0;
         end
      join
      wait_drain(200);
      check("t5_coincident", 32'(clr_coinc), 1);
      check("t5_crc_clr", rx.crc8, 8'h00);
      check("t5_count_clr", rx.byte_count, 0);
      check("t5_data", rx.data_out, 8'h03);
      send_frame(8'h01, 1, BIT_NS);
      wait_drain(200);
      check("t5_crc_after", rx.crc8, 8'h07);
      check("t5_count_after", rx.byte_count, 1);

      // T6: 256 bytes with +/-3% bit period, count wraps to zero
      do_clear();
      for (int i = 0; i < 256; i++) begin
         send_frame(8'(i), 1, (i < 128) ? BIT_NS * 1.03 : BIT_NS * 0.97);
         #(2 * BIT_NS);
      end
      wait_drain(400);
      check("t6_count_wrap", rx.byte_count, 0);
      check("t6_model_count", m_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
